// File: rtl/acc_bank_array.sv
// acc_bank_array: NUM_COLS-wide accumulator store between the systolic array
// and the PPU. Two-stage write pipeline (S0 fetch/forward, S1 compute/commit)
// with per-column masking, optional saturation with sticky overflow flags,
// a row-by-row clear sequencer and a one-cycle registered read port.
module acc_bank_array #(
  parameter int NUM_COLS   = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int ACC_WIDTH  = 32,
  parameter bit SAT_EN     = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear_start,
  output logic                          busy,
  input  logic                          wr_valid,
  input  logic [DEPTH_LOG2-1:0]         wr_addr,
  input  logic                          acc_mode,
  input  logic [NUM_COLS-1:0]           wr_mask,
  input  logic [NUM_COLS*ACC_WIDTH-1:0] in_psum,
  input  logic                          rd_req,
  input  logic [DEPTH_LOG2-1:0]         rd_addr,
  output logic                          rd_valid,
  output logic [NUM_COLS*ACC_WIDTH-1:0] rd_data,
  output logic [NUM_COLS-1:0]           ovf_sticky
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int ROW_W = NUM_COLS * ACC_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   clr_row_q;
  logic                    clr_accept, wr_accept, rd_accept;

  // Row-wide storage; no reset, software clears before first use.
  logic [ROW_W-1:0]        mem [DEPTH];

  logic [ROW_W-1:0]        old_p0, rd_row_p0;

  logic                    vld_p1;
  logic [DEPTH_LOG2-1:0]   addr_p1;
  logic                    mode_p1;
  logic [NUM_COLS-1:0]     mask_p1;
  logic [ROW_W-1:0]        psum_p1, old_p1, new_p1;
  logic [NUM_COLS-1:0]     ovf_p1;

  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_waddr;
  logic [ROW_W-1:0]        mem_wrow;

  // Signed overflow: operands share a sign and the wrapped sum does not.
  function automatic logic add_ovf(input logic signed [ACC_WIDTH-1:0] a,
                                   input logic signed [ACC_WIDTH-1:0] b);
    logic signed [ACC_WIDTH-1:0] s;
    s = a + b;
    return (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
  endfunction

  // Accumulate with optional clamp to the signed range.
  function automatic logic signed [ACC_WIDTH-1:0] sat_add(input logic signed [ACC_WIDTH-1:0] a,
                                                          input logic signed [ACC_WIDTH-1:0] b);
    logic signed [ACC_WIDTH-1:0] s;
    s = a + b;
    if (SAT_EN && add_ovf(a, b)) s = a[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
    return s;
  endfunction

  // A clear request wins the cycle: the write beside it is dropped, a read is not.
  assign clr_accept = (state_q == IDLE) && clear_start;
  assign wr_accept  = (state_q == IDLE) && wr_valid && !clear_start;
  assign rd_accept  = (state_q == IDLE) && rd_req;
  assign busy       = (state_q == CLEAR);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: sweep every row once, then fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear_start) state_d = CLEAR;
      CLEAR:   if (clr_row_q == '1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Clear row pointer, restarted at zero on every accepted clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                clr_row_q <= '0;
    else if (clr_accept)       clr_row_q <= '0;
    else if (state_q == CLEAR) clr_row_q <= clr_row_q + DEPTH_LOG2'(1);
  end

  // ---- S0: fetch old row / read row, forwarding S1's masked-in columns ----
  always_comb begin
    old_p0    = mem[wr_addr];
    rd_row_p0 = mem[rd_addr];
    for (int c = 0; c < NUM_COLS; c++) begin
      if (vld_p1 && mask_p1[c] && (addr_p1 == wr_addr))
        old_p0[c*ACC_WIDTH +: ACC_WIDTH] = new_p1[c*ACC_WIDTH +: ACC_WIDTH];
      if (vld_p1 && mask_p1[c] && (addr_p1 == rd_addr))
        rd_row_p0[c*ACC_WIDTH +: ACC_WIDTH] = new_p1[c*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  // S1 valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= wr_accept;
  end

  // S1 payload; only meaningful while vld_p1 is set.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      addr_p1 <= wr_addr;
      mode_p1 <= acc_mode;
      mask_p1 <= wr_mask;
      psum_p1 <= in_psum;
      old_p1  <= old_p0;
    end
  end

  // ---- S1: compute new row; overwrite mode never saturates ----
  always_comb begin
    new_p1 = psum_p1;
    ovf_p1 = '0;
    if (mode_p1) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        new_p1[c*ACC_WIDTH +: ACC_WIDTH] = sat_add(old_p1[c*ACC_WIDTH +: ACC_WIDTH],
                                                   psum_p1[c*ACC_WIDTH +: ACC_WIDTH]);
        ovf_p1[c] = SAT_EN && add_ovf(old_p1[c*ACC_WIDTH +: ACC_WIDTH],
                                      psum_p1[c*ACC_WIDTH +: ACC_WIDTH]);
      end
    end
  end

  // Single write port: clear sweep and S1 commit never overlap, since writes
  // are dropped from the clear_start cycle onward.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_p1;
    mem_wrow  = mem[addr_p1];
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_row_q;
      mem_wrow  = '0;
    end else if (vld_p1) begin
      mem_we = 1'b1;
      for (int c = 0; c < NUM_COLS; c++)
        if (mask_p1[c]) mem_wrow[c*ACC_WIDTH +: ACC_WIDTH] = new_p1[c*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  // Memory write.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wrow;
  end

  // Sticky overflow flags for written columns; a clear request zeroes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          ovf_sticky <= '0;
    else if (clr_accept) ovf_sticky <= '0;
    else if (vld_p1)     ovf_sticky <= ovf_sticky | (ovf_p1 & mask_p1);
  end

  // Registered read port; rd_data holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) rd_data <= rd_row_p0;
    end
  end

endmodule

// File: doc/acc_bank_array.md
# acc_bank_array

Multi-column accumulator store for the systolic array output path. Replaces the per-column single-cycle read-modify-write bank with a NUM_COLS-wide, depth-parametrised, two-stage pipelined accumulator. Adds per-column write masking, optional saturation with sticky overflow flags, a hardware clear sequencer, and a registered read port for the PPU. Sits between the array's partial-sum outputs and the PPU.

## Interface
- NUM_COLS, 16, number of accumulator columns (array width)
- DEPTH_LOG2, 8, address bits; depth = 2^DEPTH_LOG2 rows (256 ≥ 197 tokens)
- ACC_WIDTH, 32, signed accumulator width per column
- SAT_EN, 1, 1: accumulate saturates to signed range; 0: wraps (two's complement)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear_start  in  1  request zeroing of all rows/columns
- busy  out  1  clear sequencer active
- wr_valid  in  1  write/accumulate request this cycle
- wr_addr  in  DEPTH_LOG2  target row
- acc_mode  in  1  0: overwrite, 1: accumulate
- wr_mask  in  NUM_COLS  per-column write enable
- in_psum  in  NUM_COLS*ACC_WIDTH  partial sums; column c at bits [c*ACC_WIDTH +: ACC_WIDTH]
- rd_req  in  1  read request
- rd_addr  in  DEPTH_LOG2  row to read
- rd_valid  out  1  rd_data valid (one-cycle pulse)
- rd_data  out  NUM_COLS*ACC_WIDTH  row contents, same packing as in_psum
- ovf_sticky  out  NUM_COLS  per-column saturation event since last clear

## Operation
- FSM states: IDLE, CLEAR.
- IDLE → CLEAR on clear_start. CLEAR walks rows 0..2^DEPTH_LOG2−1, one per cycle, writing 0 to all columns. After the last row it returns to IDLE. busy = (state == CLEAR).
- clear_start is ignored while in CLEAR. wr_valid and rd_req are ignored (dropped) while busy.
- In the clear_start cycle itself, wr_valid is dropped and rd_req is served. ovf_sticky is zeroed on the clear_start edge.
- Write pipeline, stage S0 (accept cycle): sample addr, mode, mask, and psum. Fetch the old row, with forwarding: if S1 is valid with the same addr, use S1's new value for columns it masks in; otherwise use memory. Register everything into S1.
- Write pipeline, stage S1: next = acc_mode ? old + psum : psum. Write columns with mask = 1 at the end of the cycle. Columns with mask = 0 are untouched.
- Saturation (SAT_EN = 1, accumulate only): on signed overflow, clamp to 2^(ACC_WIDTH−1)−1 or −2^(ACC_WIDTH−1) and set ovf_sticky[c]. Overwrite mode never saturates.
- SAT_EN = 0: wrap, and ovf_sticky stays 0.
- Read: rd_req is sampled in cycle T. The row content, forwarded from S1 if S1 holds the same addr, is registered into rd_data with rd_valid = 1 in T+1. A write accepted in the same cycle T is not visible to that read.
- rd_data holds its last value when rd_valid = 0.
- Memory has no reset and is undefined after reset (the simulation model zero-initialises it). Software must issue clear before first use.

## Timing
- Reset values: state IDLE, busy 0, S1 valid 0, rd_valid 0, rd_data 0, ovf_sticky 0.
- Reset mid-CLEAR aborts the sweep; rows not yet reached keep their old contents.
- Write throughput is 1 per cycle. Back-to-back accumulates to the same addr are exact via forwarding.
- Write accepted at T is committed at edge T+1. A read requested at T+2 or later sees it from memory; a read at T+1 sees it via forwarding.
- Read latency is 1 cycle. Read and write may be issued in the same cycle to any addresses.
- clear_start accepted at T: the in-flight S1 write from T−1 still commits at the end of T. busy is high from T+1 through T+2^DEPTH_LOG2 (row r is zeroed in cycle T+1+r). IDLE is reached at T+2^DEPTH_LOG2+1.
- wr_addr and rd_addr span the full power-of-two range. There is no wrap or bounds logic.

## Test plan
- Reset, then clear (DEPTH_LOG2=8) → busy high for exactly 256 cycles; reading rows 0, 128, 255 returns all zeros.
- Overwrite row 5 with col c = c+1, then 3 consecutive accumulates of +10 → read row 5 gives c+31 for every column.
- Accumulate to row 7 on consecutive cycles with wr_mask alternating 0x5555/0xAAAA → masked-off columns are unchanged and forwarding is correct per column.
- SAT_EN=1: row 0 col 0 = 0x7FFFFFF0, accumulate +0x20 → reads 0x7FFFFFFF and ovf_sticky[0]=1. Then clear → ovf_sticky=0.
- Same cycle: write row 3 plus rd_req row 3 → rd_data shows the pre-write value. rd_req row 3 one cycle later → shows the new value.
- Assert rst_n low at row 100 of a clear → busy drops immediately. Row 50 reads 0; row 200 keeps its prior value.
